// File: rtl/dipole_sweep.sv
// dipole_sweep: raster sweep sequencer feeding `dipole`, with a dipole-state grid and registered read port.
// Define DIPOLE_SWEEP_STATS_EN to build the saturating flip counter; otherwise flip_count is tied to 0.
module dipole_sweep #(
    parameter int WRITE_WIDTH  = 8,
    parameter int WRITE_HEIGHT = 8,
    parameter int RADIUS       = 4,
    parameter int PASS_BITS    = 4,
    parameter int COUNT_BITS   = 16,
    localparam int WIDTH       = WRITE_WIDTH + 2 * RADIUS,
    localparam int HEIGHT      = WRITE_HEIGHT + 2 * RADIUS,
    localparam int NUM_WRITES  = WRITE_WIDTH * WRITE_HEIGHT,
    localparam int WIDTH_BITS  = $clog2(WIDTH),
    localparam int HEIGHT_BITS = $clog2(HEIGHT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [NUM_WRITES-1:0]  cmd_strobe,
    input  logic [NUM_WRITES-1:0]  cmd_data,
    input  logic [PASS_BITS-1:0]   cmd_passes,
    output logic                   cmd_done,
    output logic                   busy,
    output logic                   write_valid,
    input  logic                   write_ready,
    output logic [NUM_WRITES-1:0]  write_strobe,
    output logic [NUM_WRITES-1:0]  write_data,
    output logic [WIDTH_BITS-1:0]  dipole_x,
    output logic [HEIGHT_BITS-1:0] dipole_y,
    input  logic                   dipole_update,
    input  logic                   dipole_value,
    input  logic [WIDTH_BITS-1:0]  rd_x,
    input  logic [HEIGHT_BITS-1:0] rd_y,
    output logic                   rd_value,
    output logic [COUNT_BITS-1:0]  flip_count
);
    localparam int CELLS     = WIDTH * HEIGHT;
    localparam int CELL_BITS = $clog2(CELLS);
    localparam logic [WIDTH_BITS-1:0]  X_LAST = WIDTH_BITS'(WIDTH - 1);
    localparam logic [HEIGHT_BITS-1:0] Y_LAST = HEIGHT_BITS'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t                  state_q;
    logic                    ready_q, valid_q, done_q, rd_q;
    logic [NUM_WRITES-1:0]   strobe_q, data_q;
    logic [PASS_BITS-1:0]    passes_q;
    logic [WIDTH_BITS-1:0]   x_q;
    logic [HEIGHT_BITS-1:0]  y_q;
    logic [CELLS-1:0]        grid_q;
    logic [CELL_BITS-1:0]    wr_idx, rd_idx;
    logic                    rd_in, hs;

    assign wr_idx = CELL_BITS'(int'(y_q) * WIDTH + int'(x_q));
    assign rd_idx = CELL_BITS'(int'(rd_y) * WIDTH + int'(rd_x));
    assign rd_in  = (int'(rd_x) < WIDTH) && (int'(rd_y) < HEIGHT);
    assign hs     = (state_q == SWEEP) && write_ready;

    assign cmd_ready    = ready_q;
    assign busy         = ~ready_q;
    assign write_valid  = valid_q;
    assign cmd_done     = done_q;
    assign write_strobe = strobe_q;
    assign write_data   = data_q;
    assign dipole_x     = x_q;
    assign dipole_y     = y_q;
    assign rd_value     = rd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            rd_q     <= 1'b0;
            strobe_q <= '0;
            data_q   <= '0;
            passes_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            grid_q   <= '0;
        end else begin
            rd_q <= rd_in && grid_q[rd_idx];
            case (state_q)
                IDLE: if (cmd_valid) begin
                    strobe_q <= cmd_strobe;
                    data_q   <= cmd_data;
                    passes_q <= cmd_passes;
                    x_q      <= '0;
                    y_q      <= '0;
                    ready_q  <= 1'b0;
                    valid_q  <= cmd_passes != '0;
                    done_q   <= cmd_passes == '0;
                    state_q  <= (cmd_passes != '0) ? SWEEP : DONE;
                end
                SWEEP: if (write_ready) begin
                    if (dipole_update) grid_q[wr_idx] <= dipole_value;
                    if (x_q != X_LAST) begin
                        x_q <= x_q + WIDTH_BITS'(1);
                    end else if (y_q != Y_LAST) begin
                        x_q <= '0;
                        y_q <= y_q + HEIGHT_BITS'(1);
                    end else begin
                        x_q      <= '0;
                        y_q      <= '0;
                        passes_q <= passes_q - PASS_BITS'(1);
                        if (passes_q == PASS_BITS'(1)) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DIPOLE_SWEEP_STATS_EN
    logic [COUNT_BITS-1:0] flip_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) flip_q <= '0;
        else if (state_q == IDLE && cmd_valid) flip_q <= '0;
        else if (hs && dipole_update && dipole_value != grid_q[wr_idx] && flip_q != '1)
            flip_q <= flip_q + COUNT_BITS'(1);
    end
    assign flip_count = flip_q;
`else
    assign flip_count = '0;
`endif
endmodule

// File: tb/tb_dipole_sweep.sv
// tb_dipole_sweep: randomized dipole stub plus a raster-order reference model for dipole_sweep.
module tb_dipole_sweep;
    localparam int W = 16, H = 16, NW = 64, POS = W * H;
`ifdef DIPOLE_SWEEP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0, reset;
    logic cmd_valid, cmd_ready, cmd_done, busy;
    logic [NW-1:0] cmd_strobe, cmd_data, write_strobe, write_data;
    logic [3:0] cmd_passes;
    logic write_valid, write_ready, dipole_update, dipole_value, rd_value;
    logic [3:0] dipole_x, dipole_y, rd_x, rd_y;
    logic [15:0] flip_count;

    dipole_sweep dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_strobe(cmd_strobe), .cmd_data(cmd_data), .cmd_passes(cmd_passes),
        .cmd_done(cmd_done), .busy(busy), .write_valid(write_valid), .write_ready(write_ready),
        .write_strobe(write_strobe), .write_data(write_data), .dipole_x(dipole_x), .dipole_y(dipole_y),
        .dipole_update(dipole_update), .dipole_value(dipole_value), .rd_x(rd_x), .rd_y(rd_y),
        .rd_value(rd_value), .flip_count(flip_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int lat_min = 3, lat_max = 3, upd_mode = 1, val_mode = 0;
    int base = 0, cyc = 0, done_n = 0, done_c = 0, acc_c = 0;
    int wcnt = 0, cur_lat = 3;
    int q_x[$], q_y[$], q_u[$], q_v[$], q_c[$];
    logic ref_grid [H][W];
    int ref_flip;

    // Dipole stub: waits a (possibly random) latency per position, drives junk update/value when not ready.
    always @(negedge clk) begin
        if (reset || !write_valid || wcnt < cur_lat) begin
            write_ready   = 1'b0;
            dipole_update = 1'($urandom % 2);
            dipole_value  = 1'($urandom % 2);
            wcnt = (reset || !write_valid) ? 0 : wcnt + 1;
        end else begin
            write_ready   = 1'b1;
            wcnt          = 0;
            cur_lat       = $urandom_range(lat_max, lat_min);
            dipole_update = (upd_mode == 2) ? 1'($urandom % 2) : (upd_mode == 1);
            dipole_value  = val_mode ? 1'($urandom % 2) : (((q_x.size() - base) / POS) % 2 == 0);
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (!reset && write_valid && write_ready) begin
            q_x.push_back(int'(dipole_x)); q_y.push_back(int'(dipole_y));
            q_u.push_back(int'(dipole_update)); q_v.push_back(int'(dipole_value));
            q_c.push_back(cyc);
        end
        if (!reset && cmd_done) begin done_n++; done_c = cyc; end
        if (!reset && cmd_valid && cmd_ready) acc_c = cyc;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) ref_grid[y][x] = 1'b0;
    endtask

    task automatic read_cell(input int x, input int y, output logic v);
        @(negedge clk); rd_x = 4'(x); rd_y = 4'(y);
        @(negedge clk); v = rd_value;
    endtask

    task automatic check_grid(input string tag);
        int bad = 0;
        logic v;
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) begin
            read_cell(x, y, v);
            if (v !== ref_grid[y][x]) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic run(input int p, input int pulse_at, input bit consec);
        logic [NW-1:0] stb = {$urandom, $urandom}, dat = {$urandom, $urandom};
        int d0 = done_n, n, bad = 0;
        bit pulsed = 0;
        base = q_x.size();
        @(negedge clk);
        chk("ready_idle", cmd_ready, 1);
        cmd_strobe = stb; cmd_data = dat; cmd_passes = 4'(p); cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (p != 0) begin
            chk("first_valid", write_valid, 1);
            chk("strobe_cap", write_strobe, stb);
            chk("data_cap", write_data, dat);
        end
        for (int i = 0; i < 20000 && done_n == d0; i++) begin
            if (pulse_at >= 0 && !pulsed && q_x.size() - base >= pulse_at) begin
                pulsed = 1;
                chk("ready_busy", cmd_ready, 0);
                chk("busy_sweep", busy, 1);
                cmd_passes = 4'd1; cmd_valid = 1'b1;
            end else cmd_valid = 1'b0;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("done_seen", done_n != d0, 1);
        repeat (4) @(negedge clk);
        chk("done_once", done_n, d0 + 1);
        n = q_x.size() - base;
        chk("hs_count", n, p * POS);
        ref_flip = 0;
        for (int i = 0; i < n && i < p * POS; i++) begin
            int ex = i % W, ey = (i / W) % H;
            if (q_x[base + i] != ex || q_y[base + i] != ey) bad++;
            if (consec && q_c[base + i] != q_c[base] + i) bad++;
            if (q_u[base + i] != 0) begin
                if (q_v[base + i] != int'(ref_grid[ey][ex]) && ref_flip < 65535) ref_flip++;
                ref_grid[ey][ex] = 1'(q_v[base + i]);
            end
        end
        chk("hs_order", bad, 0);
        if (p == 0) chk("done_lat0", done_c, acc_c + 1);
        else if (n > 0) chk("done_lat", done_c, q_c[q_c.size() - 1] + 1);
        chk("flip_count", flip_count, STATS ? ref_flip : 0);
        chk("idle_after", cmd_ready, 1);
    endtask

    initial begin
        logic v;
        reset = 1'b1; cmd_valid = 0; cmd_strobe = '0; cmd_data = '0; cmd_passes = '0;
        rd_x = 4'd5; rd_y = 4'd5;
        clear_model();
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", write_valid, 0);
        chk("rst_done", cmd_done, 0);
        chk("rst_xy", {dipole_x, dipole_y}, 0);
        chk("rst_wr", {write_strobe, write_data}, 0);
        reset = 1'b0;
        read_cell(5, 5, v);
        chk("rst_rd", v, 0);
        chk("rst_flip", flip_count, 0);

        run(1, -1, 0);
        check_grid("grid_ones");

        lat_min = 0; lat_max = 0; upd_mode = 2; val_mode = 1;
        run(1, -1, 1);
        check_grid("grid_rand");

        @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
        clear_model();
        lat_max = 3; upd_mode = 0;
        run(1, -1, 0);
        check_grid("grid_noupd");

        lat_max = 2; upd_mode = 1; val_mode = 0;
        run(3, 300, 0);
        check_grid("grid_3pass");

        run(0, -1, 0);

        lat_max = 1; val_mode = 1;
        base = q_x.size();
        @(negedge clk); cmd_passes = 4'd1; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        for (int i = 0; i < 2000 && q_x.size() - base < 100; i++) @(posedge clk);
        chk("hs100_seen", q_x.size() - base >= 100, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", write_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", cmd_ready, 1);
        chk("arst_xy", {dipole_x, dipole_y}, 0);
        chk("arst_flip", flip_count, 0);
        @(negedge clk); @(negedge clk); reset = 1'b0;
        clear_model();
        check_grid("grid_arst");
        chk("arst_idle", cmd_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
